// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the mem_arb memory arbiter.
// Holds FSM state encoding, access-size codes and the alignment helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  function automatic logic misaligned(
    input logic [1:0] lo,
    input logic [1:0] size
  );
    logic bad;
    bad = 1'b1;
    unique case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = lo[0];
      SIZE_WORD: bad = (lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Fetch/data grant selection with a saturating fetch starvation counter.
// Data wins by default; fetch is forced through after STARVE_LIMIT losses.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle,
  input  logic i_valid,
  input  logic d_valid,
  output logic i_grant,
  output logic d_grant
);

  localparam int CW =
    (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_q;
  logic          force_i;

  assign force_i = (starve_q == CW'(STARVE_LIMIT));

  assign i_grant = idle && i_valid && (!d_valid || force_i);
  assign d_grant = idle && d_valid && !(i_valid && force_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (idle) begin
      if (!i_valid || i_grant) begin
        starve_q <= '0;
      end else if (!force_i) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Two-requester memory arbiter: fetch port and load/store port, 3-cycle FSM.
// Optional misalignment trap enabled by defining MEM_ARB_MISALIGN_TRAP_EN.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_SIZE    = 10,
  parameter int WORD_SIZE    = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_req_valid,
  output logic                 i_req_ready,
  input  logic [ADDR_SIZE-1:0] i_req_addr,
  output logic                 i_rsp_valid,
  output logic [WORD_SIZE-1:0] i_rsp_data,
  input  logic                 d_req_valid,
  output logic                 d_req_ready,
  input  logic                 d_req_write,
  input  logic [ADDR_SIZE-1:0] d_req_addr,
  input  logic [WORD_SIZE-1:0] d_req_wdata,
  input  logic [1:0]           d_req_size,
  input  logic                 d_req_unsigned,
  output logic                 d_rsp_valid,
  output logic [WORD_SIZE-1:0] d_rsp_data,
  output logic                 d_rsp_err,
  output logic                 m_en_write,
  output logic                 m_en_read,
  output logic [ADDR_SIZE-1:0] m_addr,
  output logic [WORD_SIZE-1:0] m_din,
  output logic [1:0]           m_size,
  output logic                 m_unsigned,
  input  logic [WORD_SIZE-1:0] m_dout
);

  state_t state_q, state_d;
  logic   own_d_q;
  logic   write_q;
  logic   err_q;
  logic   idle;
  logic   hs;

  // Grants are suppressed while reset is held so no handshake is visible.
  assign idle = (state_q == IDLE) && rst_n;
  assign hs   = i_req_ready || d_req_ready;

  mem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk     (clk),
    .rst_n   (rst_n),
    .idle    (idle),
    .i_valid (i_req_valid),
    .d_valid (d_req_valid),
    .i_grant (i_req_ready),
    .d_grant (d_req_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hs) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_d_q    <= 1'b0;
      write_q    <= 1'b0;
      m_addr     <= '0;
      m_din      <= '0;
      m_size     <= '0;
      m_unsigned <= 1'b0;
    end else if (i_req_ready) begin
      own_d_q    <= 1'b0;
      write_q    <= 1'b0;
      m_addr     <= i_req_addr;
      m_size     <= SIZE_WORD;
      m_unsigned <= 1'b1;
    end else if (d_req_ready) begin
      own_d_q    <= 1'b1;
      write_q    <= d_req_write;
      m_addr     <= d_req_addr;
      m_size     <= d_req_size;
      m_unsigned <= d_req_unsigned;
      if (d_req_write) m_din <= d_req_wdata;
    end
  end

`ifdef MEM_ARB_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (hs) begin
      err_q <= d_req_ready &&
               misaligned(d_req_addr[1:0], d_req_size);
    end
  end
`else
  assign err_q = 1'b0;
`endif

  always_comb begin
    m_en_read   = 1'b0;
    m_en_write  = 1'b0;
    i_rsp_valid = 1'b0;
    d_rsp_valid = 1'b0;
    i_rsp_data  = '0;
    d_rsp_data  = '0;
    d_rsp_err   = 1'b0;
    if (state_q == ACCESS && !err_q) begin
      m_en_write = own_d_q && write_q;
      m_en_read  = !(own_d_q && write_q);
    end
    if (state_q == RESP) begin
      i_rsp_valid = !own_d_q;
      d_rsp_valid = own_d_q;
      d_rsp_err   = own_d_q && err_q;
      if (!own_d_q) i_rsp_data = m_dout;
      if (own_d_q && !write_q && !err_q) d_rsp_data = m_dout;
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with response scoreboard and memory model.
// Honours MEM_ARB_MISALIGN_TRAP_EN for error expectations.
module tb_mem_arb;

  typedef struct {
    bit          is_d;
    bit          err;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid;
  logic        i_req_ready;
  logic [9:0]  i_req_addr;
  logic        i_rsp_valid;
  logic [31:0] i_rsp_data;
  logic        d_req_valid;
  logic        d_req_ready;
  logic        d_req_write;
  logic [9:0]  d_req_addr;
  logic [31:0] d_req_wdata;
  logic [1:0]  d_req_size;
  logic        d_req_unsigned;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic        d_rsp_err;
  logic        m_en_write;
  logic        m_en_read;
  logic [9:0]  m_addr;
  logic [31:0] m_din;
  logic [1:0]  m_size;
  logic        m_unsigned;
  logic [31:0] m_dout = '0;

  int   passed = 0;
  int   total  = 0;
  exp_t sb[$];

  mem_arb dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req_valid    (i_req_valid),
    .i_req_ready    (i_req_ready),
    .i_req_addr     (i_req_addr),
    .i_rsp_valid    (i_rsp_valid),
    .i_rsp_data     (i_rsp_data),
    .d_req_valid    (d_req_valid),
    .d_req_ready    (d_req_ready),
    .d_req_write    (d_req_write),
    .d_req_addr     (d_req_addr),
    .d_req_wdata    (d_req_wdata),
    .d_req_size     (d_req_size),
    .d_req_unsigned (d_req_unsigned),
    .d_rsp_valid    (d_rsp_valid),
    .d_rsp_data     (d_rsp_data),
    .d_rsp_err      (d_rsp_err),
    .m_en_write     (m_en_write),
    .m_en_read      (m_en_read),
    .m_addr         (m_addr),
    .m_din          (m_din),
    .m_size         (m_size),
    .m_unsigned     (m_unsigned),
    .m_dout         (m_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [9:0] a);
    return {22'b0, a} ^ 32'h3;
  endfunction

  always @(posedge clk) begin
    if (m_en_read) m_dout <= memf(m_addr);
  end

  function automatic bit mis(input logic [9:0] a, input logic [1:0] s);
`ifdef MEM_ARB_MISALIGN_TRAP_EN
    return (s == 2'b01 && a[0]) ||
           (s == 2'b10 && a[1:0] != 2'b00) ||
           (s == 2'b11);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (i_rsp_valid || d_rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", {i_rsp_valid, d_rsp_valid}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_port", {30'b0, i_rsp_valid, d_rsp_valid},
            e.is_d ? 32'd1 : 32'd2);
        chk("rsp_data", e.is_d ? d_rsp_data : i_rsp_data, e.data);
        chk("rsp_err", {31'b0, d_rsp_err}, {31'b0, e.err});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input bit is_d, input bit wr,
                      input logic [9:0] a, input logic [31:0] wd,
                      input logic [1:0] sz, input bit uns);
    exp_t e;
    bit   err;
    err = is_d && mis(a, sz);
    i_req_valid = !is_d;
    i_req_addr  = a;
    d_req_valid = is_d;
    d_req_write = wr;
    d_req_addr  = a;
    d_req_wdata = wd;
    d_req_size  = sz;
    d_req_unsigned = uns;
    #1;
    chk("i_ready", {31'b0, i_req_ready}, {31'b0, !is_d});
    chk("d_ready", {31'b0, d_req_ready}, {31'b0, is_d});
    e.is_d = is_d;
    e.err  = err;
    e.data = (err || wr) ? 32'h0 : memf(a);
    sb.push_back(e);
    step();
    chk("busy_ready", {30'b0, i_req_ready, d_req_ready}, 0);
    chk("acc_rd", {31'b0, m_en_read}, {31'b0, !err && !(is_d && wr)});
    chk("acc_wr", {31'b0, m_en_write}, {31'b0, !err && is_d && wr});
    chk("acc_size", {30'b0, m_size}, {30'b0, is_d ? sz : 2'b10});
    chk("acc_uns", {31'b0, m_unsigned}, {31'b0, is_d ? uns : 1'b1});
    if (!err) chk("acc_addr", {22'b0, m_addr}, {22'b0, a});
    if (is_d && wr && !err) chk("acc_din", m_din, wd);
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    step();
    chk("resp_en", {30'b0, m_en_read, m_en_write}, 0);
    step();
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    i_req_valid = 1'b0;
    i_req_addr = '0;
    d_req_valid = 1'b1;
    d_req_write = 1'b0;
    d_req_addr = '0;
    d_req_wdata = '0;
    d_req_size = 2'b10;
    d_req_unsigned = 1'b0;
    step();
    step();
    chk("rst_ready", {30'b0, i_req_ready, d_req_ready}, 0);
    chk("rst_en", {30'b0, m_en_read, m_en_write}, 0);
    chk("rst_rsp", {29'b0, i_rsp_valid, d_rsp_valid, d_rsp_err}, 0);
    chk("rst_addr", {22'b0, m_addr}, 0);
    chk("rst_din", m_din, 0);
    chk("rst_size", {29'b0, m_size, m_unsigned}, 0);
    chk("rst_data", i_rsp_data | d_rsp_data, 0);
    d_req_valid = 1'b0;
    rst_n = 1'b1;
    step();

    xact(1'b0, 1'b0, 10'h010, 32'h0, 2'b10, 1'b1);
    xact(1'b1, 1'b1, 10'h003, 32'hAB00_0000, 2'b00, 1'b0);
    xact(1'b1, 1'b0, 10'h002, 32'h0, 2'b10, 1'b0);
    xact(1'b1, 1'b0, 10'h006, 32'h0, 2'b01, 1'b0);
    xact(1'b1, 1'b0, 10'h005, 32'h0, 2'b01, 1'b1);
    xact(1'b1, 1'b0, 10'h004, 32'h0, 2'b11, 1'b0);
    xact(1'b1, 1'b1, 10'h008, 32'hDEAD_BEEF, 2'b10, 1'b0);

    i_req_addr  = 10'h030;
    d_req_addr  = 10'h020;
    d_req_write = 1'b0;
    d_req_size  = 2'b10;
    i_req_valid = 1'b1;
    d_req_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bit f;
      f = (k % 5) == 4;
      #1;
      chk("prio_i", {31'b0, i_req_ready}, {31'b0, f});
      chk("prio_d", {31'b0, d_req_ready}, {31'b0, !f});
      e.is_d = !f;
      e.err  = 1'b0;
      e.data = f ? memf(10'h030) : memf(10'h020);
      sb.push_back(e);
      step();
      chk("prio_busy", {30'b0, i_req_ready, d_req_ready}, 0);
      step();
      step();
    end
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    step();

    d_req_valid = 1'b1;
    d_req_write = 1'b0;
    d_req_addr  = 10'h040;
    d_req_size  = 2'b10;
    #1;
    chk("pre_rst_ready", {31'b0, d_req_ready}, 1);
    step();
    chk("pre_rst_rd", {31'b0, m_en_read}, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_drop_en", {30'b0, m_en_read, m_en_write}, 0);
    sb.delete();
    step();
    step();
    chk("rst_hold_rsp", {30'b0, i_rsp_valid, d_rsp_valid}, 0);
    rst_n = 1'b1;
    xact(1'b1, 1'b0, 10'h044, 32'h0, 2'b10, 1'b0);

    step();
    step();
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Param ADDR_SIZE, 10, byte-address width shared by requesters and memory port.
REQ-002 Param WORD_SIZE, 32, data width.
REQ-003 Param STARVE_LIMIT, 4, consecutive fetch losses before fetch is forced to win.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 i_req_valid  in  1  fetch request pending.
REQ-007 i_req_ready  out  1  fetch request accepted this cycle.
REQ-008 i_req_addr  in  ADDR_SIZE  fetch byte address, word read.
REQ-009 i_rsp_valid  out  1  one-cycle pulse, fetch data valid.
REQ-010 i_rsp_data  out  WORD_SIZE  fetched word.
REQ-011 d_req_valid  in  1  load/store request pending.
REQ-012 d_req_ready  out  1  load/store accepted this cycle.
REQ-013 d_req_write  in  1  1 store, 0 load.
REQ-014 d_req_addr  in  ADDR_SIZE  load/store byte address.
REQ-015 d_req_wdata  in  WORD_SIZE  store data, byte lanes as in memory.
REQ-016 d_req_size  in  2  00 byte, 01 half, 10 word.
REQ-017 d_req_unsigned  in  1  1 zero-extend load, 0 sign-extend.
REQ-018 d_rsp_valid  out  1  one-cycle pulse, load data valid or store done.
REQ-019 d_rsp_data  out  WORD_SIZE  extended load data; 0 for stores and errors.
REQ-020 d_rsp_err  out  1  misaligned/illegal access, qualified by d_rsp_valid.
REQ-021 m_en_write  out  1  memory write enable.
REQ-022 m_en_read  out  1  memory read enable.
REQ-023 m_addr  out  ADDR_SIZE  memory byte address.
REQ-024 m_din  out  WORD_SIZE  memory write data.
REQ-025 m_size  out  2  memory access size, same encoding as d_req_size.
REQ-026 m_unsigned  out  1  memory load extension select.
REQ-027 m_dout  in  WORD_SIZE  memory read data, valid one cycle after read-enable edge.

Function
REQ-028 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on handshake, ACCESS->RESP always, RESP->IDLE always; one transaction per 3 cycles.
REQ-029 Ready asserted only in IDLE, to at most one requester (the grant), combinationally from valids; never both.
REQ-030 Grant in IDLE: data wins over fetch unless starve count == STARVE_LIMIT, then fetch wins.
REQ-031 Starve count increments (saturating at STARVE_LIMIT) when fetch is valid and loses; clears when fetch granted or i_req_valid low in IDLE.
REQ-032 Request fields registered at handshake edge N; in ACCESS (cycle N+1) m_addr/m_din/m_size/m_unsigned driven from registers, exactly one of m_en_read/m_en_write high.
REQ-033 Fetch always drives m_size=10, m_unsigned=1, m_en_read=1.
REQ-034 In RESP (cycle N+2) the owner's rsp_valid pulses one cycle; rsp_data = m_dout for reads, 0 for stores; other requester's rsp_valid stays 0.
REQ-035 m_en_read/m_en_write are 0 in IDLE and RESP; m_addr/m_din hold last value outside ACCESS.
REQ-036 A valid dropped before handshake is not an error; no request is accepted mid-transaction.

Reset
REQ-037 rst_n low at any time: state IDLE, starve count 0, all outputs 0, any in-flight response discarded without pulse.

Configuration
REQ-038 MEM_ARB_MISALIGN_TRAP_EN defined: half with addr[0]=1, word with addr[1:0]!=0, or size 11 -> no memory enable in ACCESS, RESP pulses d_rsp_valid with d_rsp_err=1, data 0.
REQ-039 MEM_ARB_MISALIGN_TRAP_EN undefined: d_rsp_err tied 0; all data requests forwarded to memory unchanged.

Structure
REQ-040 Package mem_arb_pkg holds the state enum and size constants SIZE_BYTE, SIZE_HALF, SIZE_WORD.
REQ-041 Grant and starvation counter live in sub-module mem_arb_prio; FSM and datapath registers in mem_arb.

Verification
REQ-042 Fetch only, addr 0x010, m_dout 0x00000013 -> i_req_ready cycle N, m_en_read N+1, i_rsp_valid and i_rsp_data=0x00000013 at N+2.
REQ-043 Fetch and data both valid continuously -> 4 data grants then 1 fetch grant, repeating.
REQ-044 Store byte 0xAB at 0x003 -> m_en_write=1, m_addr=0x003, m_size=00 in ACCESS; d_rsp_valid=1, d_rsp_data=0 in RESP.
REQ-045 With MEM_ARB_MISALIGN_TRAP_EN, load word at 0x002 -> no m_en_read, d_rsp_err=1 at N+2; without it, m_en_read=1, d_rsp_err=0.
REQ-046 rst_n low during ACCESS -> m_en_* drop to 0 immediately, no rsp_valid pulse, next request accepted in first IDLE cycle after release.
